// File: rtl/note_slot_if.sv
// note_slot_if: bundles the note-table control and read-port signals.
//
// master  : the side that spawns/strums/reads (game logic, renderer, bench)
// slave   : the note_slot_controller
//
// Signals
//   frame_tick              1-cycle pulse at vblank start
//   spawn_valid/ready/lane  request to allocate a note in a lane
//   strum_valid/ready/lane  player strum to resolve against the hit zone
//   hit/miss/passed         1-cycle result pulses
//   busy                    controller is walking the table
//   rd_slot/rd_active/rd_x/rd_y  combinational slot read port
//
// Handshake: a request transfers on a rising clock edge where valid and
// ready are both high. ready may depend combinationally on valid and on
// other requests; the master holds valid and its payload stable until the
// transfer, and a valid still high after a transfer is a fresh request.
interface note_slot_if #(
    parameter int SW = 3
);
    logic          frame_tick;
    logic          spawn_valid;
    logic [2:0]    spawn_lane;
    logic          spawn_ready;
    logic          strum_valid;
    logic [2:0]    strum_lane;
    logic          strum_ready;
    logic          hit;
    logic          miss;
    logic          passed;
    logic          busy;
    logic [SW-1:0] rd_slot;
    logic          rd_active;
    logic [9:0]    rd_x;
    logic [31:0]   rd_y;

    modport master (
        output frame_tick, spawn_valid, spawn_lane, strum_valid, strum_lane, rd_slot,
        input  spawn_ready, strum_ready, hit, miss, passed, busy, rd_active, rd_x, rd_y
    );

    modport slave (
        input  frame_tick, spawn_valid, spawn_lane, strum_valid, strum_lane, rd_slot,
        output spawn_ready, strum_ready, hit, miss, passed, busy, rd_active, rd_x, rd_y
    );
endinterface

// File: rtl/note_slot_controller.sv
// note_slot_controller: owns the table of falling notes.
//
// Allocates a slot on spawn, advances every active note by SPEED pixels once
// per frame, retires notes that reach SCREEN_H, and resolves strums against
// the hit zone. One slot is visited per cycle while walking the table.
//
// Ports
//   clock      system clock
//   resetn     asynchronous active-low reset
//   bus        note_slot_if.slave (spawn/strum handshakes, pulses, read port)
//   state_dbg  current FSM state (IDLE=0, ADVANCE=1, SCAN=2)
module note_slot_controller #(
    parameter int SLOTS      = 8,
    parameter int NOTE_WIDTH = 32,
    parameter int SCREEN_H   = 480,
    parameter int SPEED      = 2,
    parameter int LANE_X0    = 160,
    parameter int LANE_PITCH = 64,
    parameter int HIT_TOP    = 400,
    parameter int HIT_BOT    = 448,
    localparam int SW        = $clog2(SLOTS)
) (
    input  logic        clock,
    input  logic        resetn,
    note_slot_if.slave  bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        SCAN    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [SW-1:0]   idx, idx_n;
    logic            frame_pending, frame_pending_n;
    logic [2:0]      strum_lane_q, strum_lane_n;

    logic [SLOTS-1:0] slot_active;
    logic [2:0]       slot_lane [SLOTS];
    logic [9:0]       slot_y    [SLOTS];

    logic            free_found;
    logic [SW-1:0]   free_idx;

    logic            cur_active;
    logic [2:0]      cur_lane;
    logic [9:0]      cur_y;
    logic [10:0]     y_next;
    logic            retire;
    logic            in_zone;
    logic            match;
    logic            last;

    logic            do_spawn, do_free, do_step;
    logic            hit_c, miss_c, passed_c;
    logic            spawn_ready_c, strum_ready_c;

    // Lowest free slot: scanning downward lets the lowest index win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
    end

    assign cur_active = slot_active[idx];
    assign cur_lane   = slot_lane[idx];
    assign cur_y      = slot_y[idx];
    assign last       = (idx == SW'(SLOTS - 1));

    // 11-bit arithmetic so y + SPEED and y + NOTE_WIDTH never wrap.
    assign y_next  = {1'b0, cur_y} + 11'(SPEED);
    assign retire  = (y_next >= 11'(SCREEN_H));
    assign in_zone = (({1'b0, cur_y} + 11'(NOTE_WIDTH)) > 11'(HIT_TOP)) &&
                     ({1'b0, cur_y} < 11'(HIT_BOT));
    assign match   = cur_active && (cur_lane == strum_lane_q) && in_zone;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            idx           <= '0;
            frame_pending <= 1'b0;
            strum_lane_q  <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            frame_pending <= frame_pending_n;
            strum_lane_q  <= strum_lane_n;
        end
    end

    always_comb begin
        state_n         = state;
        idx_n           = idx;
        frame_pending_n = frame_pending;
        strum_lane_n    = strum_lane_q;
        do_spawn        = 1'b0;
        do_free         = 1'b0;
        do_step         = 1'b0;
        hit_c           = 1'b0;
        miss_c          = 1'b0;
        passed_c        = 1'b0;
        spawn_ready_c   = 1'b0;
        strum_ready_c   = 1'b0;

        case (state)
            IDLE: begin
                strum_ready_c = !bus.frame_tick && !frame_pending;
                spawn_ready_c = free_found && !bus.frame_tick && !frame_pending &&
                                !bus.strum_valid;
                if (bus.frame_tick || frame_pending) begin
                    frame_pending_n = 1'b0;
                    idx_n           = '0;
                    state_n         = ADVANCE;
                end else if (bus.strum_valid) begin
                    strum_lane_n = bus.strum_lane;
                    idx_n        = '0;
                    state_n      = SCAN;
                end else if (bus.spawn_valid && free_found) begin
                    do_spawn = 1'b1;
                end
            end

            ADVANCE: begin
                // Ticks arriving mid-walk collapse into a single pending advance.
                if (bus.frame_tick) frame_pending_n = 1'b1;
                if (cur_active) begin
                    if (retire) begin
                        do_free  = 1'b1;
                        passed_c = 1'b1;
                    end else begin
                        do_step = 1'b1;
                    end
                end
                idx_n = idx + 1'b1;
                if (last) state_n = IDLE;
            end

            SCAN: begin
                if (bus.frame_tick) frame_pending_n = 1'b1;
                idx_n = idx + 1'b1;
                if (match) begin
                    do_free = 1'b1;
                    hit_c   = 1'b1;
                    state_n = IDLE;
                end else if (last) begin
                    miss_c  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // Slot table; only one of spawn/free/step can be active in a given state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_active <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_lane[i] <= '0;
                slot_y[i]    <= '0;
            end
        end else begin
            if (do_spawn) begin
                slot_active[free_idx] <= 1'b1;
                slot_lane[free_idx]   <= bus.spawn_lane;
                slot_y[free_idx]      <= '0;
            end
            if (do_free) begin
                slot_active[idx] <= 1'b0;
                slot_lane[idx]   <= '0;
                slot_y[idx]      <= '0;
            end
            if (do_step) begin
                slot_y[idx] <= y_next[9:0];
            end
        end
    end

    // Combinational read port; inactive slots read as zero.
    logic       rd_act;
    logic [2:0] rd_lane;
    logic [9:0] rd_ypos;
    logic [9:0] lane_x;

    assign rd_act  = slot_active[bus.rd_slot];
    assign rd_lane = slot_lane[bus.rd_slot];
    assign rd_ypos = slot_y[bus.rd_slot];
    assign lane_x  = 10'(LANE_X0) + ({7'd0, rd_lane} * 10'(LANE_PITCH));

    assign bus.rd_active   = rd_act;
    assign bus.rd_x        = rd_act ? lane_x : 10'd0;
    assign bus.rd_y        = rd_act ? {22'd0, rd_ypos} : 32'd0;

    assign bus.spawn_ready = spawn_ready_c;
    assign bus.strum_ready = strum_ready_c;
    assign bus.hit         = hit_c;
    assign bus.miss        = miss_c;
    assign bus.passed      = passed_c;
    assign bus.busy        = (state != IDLE);
    assign state_dbg       = state;

endmodule

// File: tb/tb_note_slot_controller.sv
// tb_note_slot_controller: directed bench for note_slot_controller.
// dut0 uses the default parameters; dut1 uses SPEED=1 so odd y values
// around the hit-zone edges can be reached.
`timescale 1ns/1ps
module tb_note_slot_controller;

    localparam int SLOTS = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // ---------------- stimulus and observed signals ----------------
    logic [1:0] frame_tick  = '0;
    logic [1:0] spawn_valid = '0;
    logic [1:0] strum_valid = '0;
    logic [2:0] spawn_lane [2];
    logic [2:0] strum_lane [2];
    logic [2:0] rd_slot    [2];

    wire [1:0]  spawn_ready, strum_ready, hit, miss, passed, busy, rd_active;
    wire [9:0]  rd_x [2];
    wire [31:0] rd_y [2];
    wire [1:0]  state_dbg [2];

    note_slot_if #(.SW(3)) if0 ();
    note_slot_if #(.SW(3)) if1 ();

    assign if0.frame_tick  = frame_tick[0];
    assign if0.spawn_valid = spawn_valid[0];
    assign if0.spawn_lane  = spawn_lane[0];
    assign if0.strum_valid = strum_valid[0];
    assign if0.strum_lane  = strum_lane[0];
    assign if0.rd_slot     = rd_slot[0];
    assign spawn_ready[0]  = if0.spawn_ready;
    assign strum_ready[0]  = if0.strum_ready;
    assign hit[0]          = if0.hit;
    assign miss[0]         = if0.miss;
    assign passed[0]       = if0.passed;
    assign busy[0]         = if0.busy;
    assign rd_active[0]    = if0.rd_active;
    assign rd_x[0]         = if0.rd_x;
    assign rd_y[0]         = if0.rd_y;

    assign if1.frame_tick  = frame_tick[1];
    assign if1.spawn_valid = spawn_valid[1];
    assign if1.spawn_lane  = spawn_lane[1];
    assign if1.strum_valid = strum_valid[1];
    assign if1.strum_lane  = strum_lane[1];
    assign if1.rd_slot     = rd_slot[1];
    assign spawn_ready[1]  = if1.spawn_ready;
    assign strum_ready[1]  = if1.strum_ready;
    assign hit[1]          = if1.hit;
    assign miss[1]         = if1.miss;
    assign passed[1]       = if1.passed;
    assign busy[1]         = if1.busy;
    assign rd_active[1]    = if1.rd_active;
    assign rd_x[1]         = if1.rd_x;
    assign rd_y[1]         = if1.rd_y;

    note_slot_controller u_dut0 (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (if0),
        .state_dbg (state_dbg[0])
    );

    note_slot_controller #(.SPEED(1)) u_dut1 (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (if1),
        .state_dbg (state_dbg[1])
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    int hit_cnt  [2] = '{0, 0};
    int miss_cnt [2] = '{0, 0};
    int pass_cnt [2] = '{0, 0};
    int bad_pulse = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (hit[d])    hit_cnt[d]++;
            if (miss[d])   miss_cnt[d]++;
            if (passed[d]) pass_cnt[d]++;
            if ((int'(hit[d]) + int'(miss[d]) + int'(passed[d])) > 1) bad_pulse++;
            if ((hit[d] || miss[d] || passed[d]) && state_dbg[d] == 2'd0) bad_pulse++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic frames(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick[d] = 1'b1;
            tick();
            frame_tick[d] = 1'b0;
            repeat (SLOTS) tick();
        end
    endtask

    task automatic spawn(input int d, input logic [2:0] lane);
        int w;
        spawn_valid[d] = 1'b1;
        spawn_lane[d]  = lane;
        #1;
        w = 0;
        while (!spawn_ready[d] && w < 100) begin
            tick();
            w++;
        end
        check("spawn_ready", 32'(spawn_ready[d]), 1);
        tick();
        spawn_valid[d] = 1'b0;
    endtask

    task automatic strum(input int d, input logic [2:0] lane);
        int w;
        strum_valid[d] = 1'b1;
        strum_lane[d]  = lane;
        #1;
        w = 0;
        while (!strum_ready[d] && w < 100) begin
            tick();
            w++;
        end
        check("strum_ready", 32'(strum_ready[d]), 1);
        tick();
        strum_valid[d] = 1'b0;
        w = 0;
        while (busy[d] && w < 50) begin
            tick();
            w++;
        end
        check("strum_done", 32'(busy[d]), 0);
    endtask

    task automatic expect_slot(input int d, input int s, input logic act,
                               input int x, input int y);
        rd_slot[d] = 3'(s);
        tick();
        check($sformatf("d%0d_s%0d_active", d, s), 32'(rd_active[d]), 32'(act));
        check($sformatf("d%0d_s%0d_x", d, s), 32'(rd_x[d]), 32'(x));
        check($sformatf("d%0d_s%0d_y", d, s), rd_y[d], 32'(y));
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int h0, m0, p0, cnt, w;
        for (int d = 0; d < 2; d++) begin
            spawn_lane[d] = '0;
            strum_lane[d] = '0;
            rd_slot[d]    = '0;
        end

        // reset state
        repeat (3) tick();
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_active", 32'(rd_active[0]), 0);
        resetn = 1'b1;
        tick();
        check("rst_spawn_ready", 32'(spawn_ready[0]), 1);
        check("rst_strum_ready", 32'(strum_ready[0]), 1);

        // T1: reset in the middle of an advance
        spawn(0, 3'd1);
        frame_tick[0] = 1'b1;
        tick();
        frame_tick[0] = 1'b0;
        tick();
        tick();
        check("t1_in_advance", 32'(state_dbg[0]), 1);
        resetn = 1'b0;
        #1;
        check("t1_async_busy", 32'(busy[0]), 0);
        check("t1_async_slot0", 32'(rd_active[0]), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check("t1_busy", 32'(busy[0]), 0);
        for (int s = 0; s < SLOTS; s++) begin
            rd_slot[0] = 3'(s);
            tick();
            check($sformatf("t1_slot%0d_inactive", s), 32'(rd_active[0]), 0);
        end
        check("t1_no_pulses", 32'(hit_cnt[0] + miss_cnt[0] + pass_cnt[0]), 0);

        // T2: spawn lane 2 then one frame
        rd_slot[0] = 3'd0;
        spawn(0, 3'd2);
        check("t2_spawn_active", 32'(rd_active[0]), 1);
        check("t2_spawn_x", 32'(rd_x[0]), 288);
        check("t2_spawn_y", rd_y[0], 0);
        frame_tick[0] = 1'b1;
        tick();
        frame_tick[0] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy[0]) cnt++;
            tick();
        end
        check("t2_busy_cycles", 32'(cnt), 8);
        expect_slot(0, 0, 1'b1, 288, 2);

        // T3: retire at SCREEN_H; a note two pixels behind survives one more frame
        spawn(0, 3'd3);
        frames(0, 238);
        expect_slot(0, 0, 1'b1, 288, 478);
        expect_slot(0, 1, 1'b1, 352, 476);
        p0 = pass_cnt[0];
        frames(0, 1);
        check("t3_pass_once", 32'(pass_cnt[0] - p0), 1);
        expect_slot(0, 0, 1'b0, 0, 0);
        expect_slot(0, 1, 1'b1, 352, 478);
        frames(0, 1);
        check("t3_pass_second", 32'(pass_cnt[0] - p0), 2);
        expect_slot(0, 1, 1'b0, 0, 0);

        // T4 (SPEED=1 instance): hit-zone edges 368/369/447/448
        spawn(1, 3'd2);
        frames(1, 1);
        spawn(1, 3'd1);
        frames(1, 1);
        spawn(1, 3'd0);
        frames(1, 368);
        expect_slot(1, 0, 1'b1, 288, 370);
        expect_slot(1, 1, 1'b1, 224, 369);
        expect_slot(1, 2, 1'b1, 160, 368);
        h0 = hit_cnt[1];
        m0 = miss_cnt[1];
        strum(1, 3'd0);
        check("t4_368_miss", 32'(miss_cnt[1] - m0), 1);
        check("t4_368_nohit", 32'(hit_cnt[1] - h0), 0);
        expect_slot(1, 2, 1'b1, 160, 368);
        strum(1, 3'd1);
        check("t4_369_hit", 32'(hit_cnt[1] - h0), 1);
        expect_slot(1, 1, 1'b0, 0, 0);
        frames(1, 77);
        expect_slot(1, 0, 1'b1, 288, 447);
        strum(1, 3'd2);
        check("t4_447_hit", 32'(hit_cnt[1] - h0), 2);
        expect_slot(1, 0, 1'b0, 0, 0);
        frames(1, 3);
        expect_slot(1, 2, 1'b1, 160, 448);
        strum(1, 3'd0);
        check("t4_448_miss", 32'(miss_cnt[1] - m0), 2);
        check("t4_448_nohit", 32'(hit_cnt[1] - h0), 2);
        expect_slot(1, 2, 1'b1, 160, 448);

        // T5: frame, strum and spawn together -> ADVANCE, SCAN, then spawn
        rd_slot[0] = 3'd0;
        m0 = miss_cnt[0];
        frame_tick[0]  = 1'b1;
        strum_valid[0] = 1'b1;
        strum_lane[0]  = 3'd4;
        spawn_valid[0] = 1'b1;
        spawn_lane[0]  = 3'd0;
        #1;
        check("t5_spawn_blocked", 32'(spawn_ready[0]), 0);
        check("t5_strum_blocked", 32'(strum_ready[0]), 0);
        tick();
        frame_tick[0] = 1'b0;
        check("t5_first_advance", 32'(state_dbg[0]), 1);
        repeat (SLOTS) tick();
        check("t5_idle_strum_ready", 32'(strum_ready[0]), 1);
        check("t5_idle_spawn_wait", 32'(spawn_ready[0]), 0);
        tick();
        strum_valid[0] = 1'b0;
        check("t5_then_scan", 32'(state_dbg[0]), 2);
        repeat (SLOTS) tick();
        check("t5_scan_miss", 32'(miss_cnt[0] - m0), 1);
        check("t5_spawn_ready", 32'(spawn_ready[0]), 1);
        tick();
        spawn_valid[0] = 1'b0;
        check("t5_spawn_active", 32'(rd_active[0]), 1);
        check("t5_spawn_x", 32'(rd_x[0]), 160);

        // T5b: tick during SCAN -> one IDLE cycle, then ADVANCE
        strum_valid[0] = 1'b1;
        strum_lane[0]  = 3'd5;
        tick();
        strum_valid[0] = 1'b0;
        check("t5b_scan", 32'(state_dbg[0]), 2);
        tick();
        tick();
        frame_tick[0] = 1'b1;
        tick();
        frame_tick[0] = 1'b0;
        w = 0;
        while (busy[0] && w < 20) begin
            tick();
            w++;
        end
        check("t5b_gap_idle", 32'(state_dbg[0]), 0);
        check("t5b_gap_spawn_ready", 32'(spawn_ready[0]), 0);
        check("t5b_gap_strum_ready", 32'(strum_ready[0]), 0);
        tick();
        check("t5b_pending_advance", 32'(state_dbg[0]), 1);
        repeat (SLOTS) tick();
        check("t5b_back_idle", 32'(busy[0]), 0);
        expect_slot(0, 0, 1'b1, 160, 2);

        // T6: fill the table, 9th spawn waits until a hit frees slot 0
        for (int l = 1; l < SLOTS; l++) spawn(0, 3'(l));
        expect_slot(0, 7, 1'b1, 608, 0);
        spawn_valid[0] = 1'b1;
        spawn_lane[0]  = 3'd3;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (spawn_ready[0]) cnt++;
        end
        check("t6_full_not_ready", 32'(cnt), 0);
        frames(0, 184);
        expect_slot(0, 0, 1'b1, 160, 370);
        expect_slot(0, 1, 1'b1, 224, 368);
        rd_slot[0] = 3'd0;
        tick();
        h0 = hit_cnt[0];
        strum(0, 3'd0);
        check("t6_hit", 32'(hit_cnt[0] - h0), 1);
        check("t6_slot0_freed", 32'(rd_active[0]), 0);
        tick();
        spawn_valid[0] = 1'b0;
        check("t6_ninth_active", 32'(rd_active[0]), 1);
        check("t6_ninth_x", 32'(rd_x[0]), 352);
        check("t6_ninth_y", rd_y[0], 0);
        expect_slot(0, 1, 1'b1, 224, 368);

        check("pulse_rules", 32'(bad_pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
